// File: rtl/pipeline_hazard_ctrl.sv
// Decode->execute pipeline register sequencer: scoreboard, flush, mem freeze.
// Optional saturating perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter int FLUSH_LEN  = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DEC_VALID,
  input  logic [2:0]  SRC_A_AD,
  input  logic [2:0]  SRC_B_AD,
  input  logic        SRC_A_USE,
  input  logic        SRC_B_USE,
  input  logic        DEC_WREN,
  input  logic [2:0]  DEC_WRITEAD,
  input  logic        PC_LOAD_EX,
  input  logic        MEM_REQ,
  input  logic        MEM_ACK,
  output logic        DEC_REG_EN,
  output logic        DEC_REG_BUBBLE,
  output logic        FETCH_HOLD,
  output logic [1:0]  STATE
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] FL_INIT = 3'(FLUSH_LEN - 1);

  state_e                     state_q, state_d;
  logic [2:0]                 fl_cnt_q, fl_cnt_d;
  logic [PIPE_DEPTH-1:0]      sb_vld_q, sb_vld_d;
  logic [PIPE_DEPTH-1:0][2:0] sb_ad_q, sb_ad_d;

  logic mem_stall;
  logic hazard;
  logic issue;
  logic frozen;
  logic en;
  logic bub;
  logic hold;

  assign mem_stall = MEM_REQ & ~MEM_ACK;

  // Compare decode reads against every in-flight register-file write
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_vld_q[i] && SRC_A_USE &&
          sb_ad_q[i] == SRC_A_AD)
        hazard = 1'b1;
      if (sb_vld_q[i] && SRC_B_USE &&
          sb_ad_q[i] == SRC_B_AD)
        hazard = 1'b1;
    end
  end

  // Per-state sequencing: mem freeze > taken PC load > hazard > issue
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    en       = 1'b1;
    bub      = 1'b1;
    hold     = 1'b0;
    frozen   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          en      = 1'b0;
          bub     = 1'b0;
          hold    = 1'b1;
          frozen  = 1'b1;
          state_d = S_MEM_WAIT;
        end else if (PC_LOAD_EX) begin
          fl_cnt_d = FL_INIT;
          state_d  = (FL_INIT == 3'd0) ? S_RUN : S_FLUSH;
        end else if (DEC_VALID && hazard) begin
          hold = 1'b1;
        end else if (DEC_VALID) begin
          bub   = 1'b0;
          issue = 1'b1;
        end
      end
      S_FLUSH: begin
        if (mem_stall) begin
          en     = 1'b0;
          bub    = 1'b0;
          hold   = 1'b1;
          frozen = 1'b1;
        end else begin
          fl_cnt_d = fl_cnt_q - 3'd1;
          if (fl_cnt_d == 3'd0)
            state_d = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        en   = 1'b0;
        bub  = 1'b0;
        hold = 1'b1;
        if (MEM_ACK)
          state_d = S_RUN;
        else
          frozen = 1'b1;
      end
      default: begin
        state_d  = S_RUN;
        fl_cnt_d = 3'd0;
      end
    endcase
    if (!RST_N) begin
      en   = 1'b1;
      bub  = 1'b1;
      hold = 1'b1;
    end
  end

  // Age the scoreboard one slot per unfrozen cycle
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_ad_d  = sb_ad_q;
    if (!frozen) begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        sb_vld_d[i] = sb_vld_q[i-1];
        sb_ad_d[i]  = sb_ad_q[i-1];
      end
      sb_vld_d[0] = issue & DEC_WREN;
      sb_ad_d[0]  = DEC_WRITEAD;
    end
  end

  // Control state, flush counter and scoreboard registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_RUN;
      fl_cnt_q <= 3'd0;
      sb_vld_q <= '0;
      sb_ad_q  <= '0;
    end else begin
      state_q  <= state_d;
      fl_cnt_q <= fl_cnt_d;
      sb_vld_q <= sb_vld_d;
      sb_ad_q  <= sb_ad_d;
    end
  end

  assign DEC_REG_EN     = en;
  assign DEC_REG_BUBBLE = bub;
  assign FETCH_HOLD     = hold;
  assign STATE          = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        haz_bub;
  logic        fl_bub;

  assign haz_bub = (state_q == S_RUN) & ~mem_stall &
                   ~PC_LOAD_EX & DEC_VALID & hazard;
  assign fl_bub  = ~mem_stall &
                   ((state_q == S_FLUSH) |
                    ((state_q == S_RUN) & PC_LOAD_EX));

  // Saturating counts of hazard and flush bubbles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (haz_bub && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (fl_bub && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Perf counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule
